// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: imem request/ack port, decode valid/ready port
// and the execute-stage redirect inputs. The master modport is the fetch unit.
interface instr_fetch_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;

    logic          instr_valid;
    logic          id_ready;
    logic [31:0]   instr;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [AW-1:0] pc_out;

    logic          br_taken;
    logic [AW-1:0] br_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, opcode, funct, pc_out,
        input  id_ready,
        input  br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, opcode, funct, pc_out,
        output id_ready,
        output br_taken, br_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the PC, fetches words over a req/ack imem port,
// presents one instruction at a time to decode and applies branch redirects.
// Optional build macro IF_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | out of reset, no request yet
//  S_REQ  | imem_req high at imem_addr, waiting for imem_ack
//  S_HOLD | instruction held for decode, waiting for id_ready
module instr_fetch #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.master bus,
    output logic         fetch_err
`ifdef IF_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] TO = 32'(TIMEOUT);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [31:0]   instr_q, instr_nxt;
    logic [AW-1:0] pc_out_q, pc_out_nxt;
    logic          valid_q, valid_nxt;
    logic          flush_q, flush_nxt;
    logic [31:0]   tcnt, tcnt_nxt;
    logic          err_q, err_nxt;
    logic [AW-1:0] tgt;

    // Redirect targets are always word aligned.
    assign tgt = {bus.br_target[AW-1:2], 2'b00};

    assign bus.imem_req    = (state == S_REQ);
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.pc_out      = pc_out_q;
    assign fetch_err       = err_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions; a redirect outranks every other event.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        addr_nxt   = addr_q;
        instr_nxt  = instr_q;
        pc_out_nxt = pc_out_q;
        valid_nxt  = valid_q;
        flush_nxt  = flush_q;
        tcnt_nxt   = '0;
        err_nxt    = err_q;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                pc_nxt    = bus.br_taken ? tgt : pc;
                addr_nxt  = bus.br_taken ? tgt : pc;
            end

            S_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.br_taken || flush_q) begin
                        // Returned word belongs to a stale path: drop it and
                        // start a fresh request at the current PC.
                        pc_nxt    = bus.br_taken ? tgt : pc;
                        addr_nxt  = bus.br_taken ? tgt : pc;
                        flush_nxt = 1'b0;
                    end else begin
                        instr_nxt  = bus.imem_rdata;
                        pc_out_nxt = pc;
                        pc_nxt     = pc + AW'(4);
                        valid_nxt  = 1'b1;
                        state_nxt  = S_HOLD;
                    end
                end else begin
                    // The outstanding request cannot be withdrawn, so a redirect
                    // only retargets the PC and marks the pending data as stale.
                    if (bus.br_taken) begin
                        pc_nxt    = tgt;
                        flush_nxt = 1'b1;
                    end
                    if (TIMEOUT != 0) begin
                        tcnt_nxt = (tcnt < TO) ? tcnt + 32'd1 : tcnt;
                        if (tcnt + 32'd1 >= TO) begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (bus.br_taken) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = tgt;
                    addr_nxt  = tgt;
                    state_nxt = S_REQ;
                end else if (bus.id_ready) begin
                    valid_nxt = 1'b0;
                    addr_nxt  = pc;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            tcnt     <= '0;
            err_q    <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            addr_q   <= addr_nxt;
            instr_q  <= instr_nxt;
            pc_out_q <= pc_out_nxt;
            valid_q  <= valid_nxt;
            flush_q  <= flush_nxt;
            tcnt     <= tcnt_nxt;
            err_q    <= err_nxt;
        end
    end

`ifdef IF_PERF_EN
    logic xfer;

    // An instruction dropped by a same-cycle redirect is not a delivered fetch.
    assign xfer = valid_q & bus.id_ready & ~bus.br_taken;

    // Delivered-instruction and decode-stall counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (xfer) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (valid_q && !bus.id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a request/hold level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;
    localparam int          AW   = 32;
    localparam logic [31:0] RP   = 32'h100;
    localparam int          TOUT = 4;

    logic clk = 1'b0;
    logic reset;
    logic fetch_err;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_if #(.AW(AW)) bus();

    instr_fetch #(.AW(AW), .RESET_PC(RP), .TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .fetch_err (fetch_err)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_started, m_req, m_valid, m_err, m_discard;
    logic [31:0] m_addr, m_next, m_instr, m_pcout;
    int          m_tcnt;
    logic [31:0] m_fetch, m_stall;

    // Advance the model by one clock using the inputs sampled at the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_started = 0; m_req = 0; m_valid = 0; m_err = 0; m_discard = 0;
            m_addr = RP; m_next = RP; m_instr = '0; m_pcout = '0;
            m_tcnt = 0; m_fetch = '0; m_stall = '0;
        end else begin
            automatic bit          br  = bus.br_taken;
            automatic logic [31:0] tgt = bus.br_target & ~32'd3;
            automatic bit          ack = bus.imem_ack;
            automatic bit          rdy = bus.id_ready;
            if (m_valid && !rdy) m_stall++;
            if (m_valid && rdy && !br) m_fetch++;
            if (!m_started) begin
                m_started = 1;
                if (br) m_next = tgt;
                m_req  = 1;
                m_addr = m_next;
            end else if (m_req) begin
                if (ack) begin
                    m_tcnt = 0;
                    if (br || m_discard) begin
                        if (br) m_next = tgt;
                        m_discard = 0;
                        m_addr    = m_next;
                    end else begin
                        m_instr = bus.imem_rdata;
                        m_pcout = m_addr;
                        m_next  = m_addr + 32'd4;
                        m_valid = 1;
                        m_req   = 0;
                    end
                end else begin
                    m_tcnt++;
                    if (m_tcnt >= TOUT) m_err = 1;
                    if (br) begin
                        m_next    = tgt;
                        m_discard = 1;
                    end
                end
            end else begin
                if (br) begin
                    m_valid = 0; m_next = tgt; m_req = 1; m_addr = tgt;
                end else if (rdy) begin
                    m_valid = 0; m_req = 1; m_addr = m_next;
                end
            end
        end
    end

    bit seen_bad = 0;

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req",   bus.imem_req, 1'b0);
            check("rst_addr",  bus.imem_addr, RP);
            check("rst_valid", bus.instr_valid, 1'b0);
            check("rst_instr", bus.instr, 32'h0);
            check("rst_pcout", bus.pc_out, 32'h0);
            check("rst_err",   fetch_err, 1'b0);
        end else begin
            check("req", bus.imem_req, m_req);
            if (m_req) check("addr", bus.imem_addr, m_addr);
            check("valid", bus.instr_valid, m_valid);
            if (m_valid) begin
                check("instr",  bus.instr, m_instr);
                check("pc_out", bus.pc_out, m_pcout);
                check("opcode", bus.opcode, m_instr[31:26]);
                check("funct",  bus.funct, m_instr[5:0]);
            end
            check("err", fetch_err, m_err);
`ifdef IF_PERF_EN
            check("perf_fetch", perf_fetch_cnt, m_fetch);
            check("perf_stall", perf_stall_cnt, m_stall);
`endif
        end
        if (bus.instr_valid && bus.instr == 32'hDEADBEEF) seen_bad = 1;
    end

    // ---------------- imem responder and stimulus ----------------
    int          ack_lat   = 0;
    bit          ack_block = 0;
    int          age       = 0;
    bit          ovr_en    = 0;
    logic [31:0] ovr_data  = '0;
    int          cyc       = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!bus.imem_req || bus.imem_ack) age = 0;
        bus.imem_ack   = bus.imem_req && !ack_block && (age >= ack_lat);
        bus.imem_rdata = ovr_en ? ovr_data : mem_word(bus.imem_addr);
        if (bus.imem_req) age++;
    endtask

    task automatic pulse_br(input logic [31:0] t);
        bus.br_taken  = 1'b1;
        bus.br_target = t;
        tick();
        bus.br_taken  = 1'b0;
    endtask

    logic [31:0] addrs[$];
    int          ack_cyc[$];

    initial begin
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
        bus.br_taken = 1'b0; bus.br_target = '0;
        repeat (3) tick();
        reset = 1'b0;

        // 1: zero-wait imem, decode always ready
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.imem_ack) begin
                addrs.push_back(bus.imem_addr);
                ack_cyc.push_back(cyc);
            end
        end
        check("t1_nfetch", addrs.size() >= 3, 1'b1);
        check("t1_addr0", addrs[0], 32'h100);
        check("t1_addr1", addrs[1], 32'h104);
        check("t1_addr2", addrs[2], 32'h108);
        check("t1_rate", ack_cyc[1] - ack_cyc[0], 2);

        // 2: LW held while decode stalls
        ovr_en = 1; ovr_data = 32'h8C220004;
        tick();
        for (int k = 0; k < 20 && !bus.imem_ack; k++) tick();
        check("t2_ack_seen", bus.imem_ack, 1'b1);
        bus.id_ready = 1'b0;
        tick();
        ovr_en = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_instr", bus.instr, 32'h8C220004);
            check("t2_opcode", bus.opcode, 6'b100011);
            check("t2_funct", bus.funct, 6'h04);
        end
`ifdef IF_PERF_EN
        check("t2_stall", perf_stall_cnt, 32'd5);
`endif

        // 3: redirect while holding, unaligned target
        pulse_br(32'h203);
        check("t3_valid", bus.instr_valid, 1'b0);
        check("t3_req", bus.imem_req, 1'b1);
        check("t3_addr", bus.imem_addr, 32'h200);
        bus.id_ready = 1'b1;
        ack_lat = 1;
        repeat (4) tick();

        // 4: redirect while a request is outstanding
        ack_lat = 3;
        for (int k = 0; k < 20 && !(bus.imem_req && !bus.imem_ack); k++) tick();
        check("t4_req_seen", bus.imem_req && !bus.imem_ack, 1'b1);
        ovr_en = 1; ovr_data = 32'hDEADBEEF;
        pulse_br(32'h40);
        for (int k = 0; k < 10 && !bus.imem_ack; k++) tick();
        check("t4_ack_seen", bus.imem_ack, 1'b1);
        ovr_en = 0;
        tick();
        check("t4_req", bus.imem_req, 1'b1);
        check("t4_addr", bus.imem_addr, 32'h40);
        check("t4_valid", bus.instr_valid, 1'b0);
        ack_lat = 1;
        repeat (6) tick();
        check("t4_no_stale", seen_bad, 1'b0);

        // 5: imem timeout
        bus.id_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.instr_valid; k++) tick();
        check("t5_hold_seen", bus.instr_valid, 1'b1);
        ack_block = 1; bus.id_ready = 1'b1;
        tick();
        repeat (3) tick();
        check("t5_err_early", fetch_err, 1'b0);
        tick();
        check("t5_err_set", fetch_err, 1'b1);
        check("t5_req_held", bus.imem_req, 1'b1);
        ack_block = 0;
        for (int k = 0; k < 10 && !bus.imem_ack; k++) tick();
        check("t5_late_ack", bus.imem_ack, 1'b1);
        repeat (2) tick();
        check("t5_err_sticky", fetch_err, 1'b1);
        reset = 1'b1;
        #1;
        check("t5_err_rst", fetch_err, 1'b0);
        tick();
        reset = 1'b0;
        repeat (4) tick();

        // 6: reset in the middle of HOLD
        bus.id_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.instr_valid; k++) tick();
        check("t6_hold_seen", bus.instr_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid_rst", bus.instr_valid, 1'b0);
        check("t6_req_rst", bus.imem_req, 1'b0);
        tick();
        reset = 1'b0;
        bus.id_ready = 1'b1;
        for (int k = 0; k < 10 && !bus.imem_ack; k++) tick();
        check("t6_ack_seen", bus.imem_ack, 1'b1);
        check("t6_restart_addr", bus.imem_addr, 32'h100);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
